// File: rtl/piso_stream.sv
// piso_stream: parametrised parallel-in/serial-out shifter with a valid/ready load and a shift_en pacing tick.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every frame.
module piso_stream #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW   = $clog2(FRAME_LEN + 1);
  localparam int HEAD = MSB_FIRST ? FRAME_LEN - 1 : 0;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_sr;
  logic [CW-1:0]          r_cnt;
  logic                   r_done;
  logic [FRAME_LEN-1:0]   w_word;
  logic [FRAME_LEN-1:0]   w_shifted;
  logic                   w_last;
  logic                   w_take;
`ifdef PISO_PARITY_EN
  // parity sits on the tail side so it leaves after every data bit
  assign w_word = MSB_FIRST ? {din, ^din} : {^din, din};
`else
  assign w_word = din;
`endif
  assign w_shifted  = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
  assign w_last     = (r_state == SHIFT) && (r_cnt == CW'(1)) && shift_en;
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_take     = load_valid && load_ready;
  // zero fill leaves r_sr empty in IDLE, so the head bit reads 0 there
  assign s_out      = r_sr[HEAD];
  assign s_valid    = (r_state == SHIFT);
  assign busy       = (r_state == SHIFT);
  assign done       = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_take) begin
        r_state <= SHIFT;
        r_sr    <= w_word;
        r_cnt   <= CW'(FRAME_LEN);
      end else if (r_state == SHIFT && shift_en) begin
        r_sr  <= w_shifted;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) r_state <= IDLE;
      end
    end
  end
endmodule
